instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Reads program words back out of `memory` after the boot loader has filled it, and hands them to the Control Unit one at a time. It drives the same active-low CS/WE/OE word interface as the loader's write path, but in the read direction only. Fetched words go into a 2-entry prefetch buffer with a valid/ready handshake. The Control Unit can redirect the fetch address for branches and jumps.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after `start`.
- `READ_WAIT`, 1: extra cycles the read is held before `Data` is sampled (0..15).
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse from bios: begin fetching at `RESET_PC`.
- `Address`  out  32  memory word address.
- `Data`  in  32  memory read data.
- `CS`  out  1  chip select, active-low.
- `WE`  out  1  write enable, active-low; held 1 at all times.
- `OE`  out  1  output enable, active-low.
- `instr`  out  32  head-of-buffer instruction.
- `instr_pc`  out  32  address `instr` was fetched from.
- `instr_valid`  out  1  buffer not empty.
- `instr_ready`  in  1  Control Unit consumes head when `instr_valid` is also high.
- `redirect`  in  1  load a new PC and flush the buffer.
- `redirect_pc`  in  32  new fetch address.
- `misalign`  out  1  sticky misaligned-redirect flag.

## Operation
- FSM states:
  - IDLE: not started.
  - READ: CS=0, OE=0; a wait counter runs 0..READ_WAIT.
  - GAP: CS=1, OE=1; one-cycle bus turnaround.
  - STALL: buffer full; CS=1, OE=1.
  - HALT: entered only under ALIGN_CHECK_EN.
- IDLE→READ when `start`=1. PC←RESET_PC.
- READ: `Address`=PC throughout. At the edge where counter==READ_WAIT:
  - capture `Data` and PC into the buffer;
  - PC←PC+4, wrapping modulo 2^32;
  - go to GAP.
- GAP→READ if the buffer count after this edge's pop is <2; otherwise GAP→STALL.
- STALL→READ on the edge after count drops below 2.
- Buffer: 2-entry FIFO.
  - Pop when `instr_valid`&&`instr_ready`.
  - Simultaneous push and pop leaves the count unchanged.
  - No push ever happens when full, because reads start only with a free slot.
- `redirect`=1 in any state except HALT:
  - PC←`redirect_pc`;
  - flush the buffer, so `instr_valid`=0 the next cycle;
  - abort any in-flight read and drop its data;
  - next state GAP.
- A redirect coinciding with a capture edge wins: the captured word is discarded.
- A redirect while in IDLE also starts fetching.
- `start` while not in IDLE is ignored.
- Reset (synchronous), taking effect at the edge:
  - state IDLE, PC=RESET_PC, buffer empty, counter 0;
  - CS=1, WE=1, OE=1, `Address`=0;
  - `instr`=0, `instr_pc`=0, `instr_valid`=0, `misalign`=0.
  - A read in progress is abandoned at that edge.

## Timing
- All outputs are registered. Nothing combinational runs from input to output.
- `start` sampled at edge E0:
  - CS/OE low from after E0;
  - `Data` sampled at edge E0+READ_WAIT+1;
  - `instr_valid`=1 from after that edge.
- Steady-state throughput: one word per READ_WAIT+2 cycles (READ cycles plus GAP).
- `Data` must be stable during the last READ cycle.
- `Address` changes only on entry to READ. It is stable while CS=0.
- CS and OE always change together. WE is never 0.

## Configuration
- `ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `misalign`=1 and forces CS=1 and OE=1.
  - The buffer is flushed and the FSM enters HALT.
  - HALT is left only by reset.
- `ALIGN_CHECK_EN` undefined:
  - `redirect_pc[1:0]` is ignored: PC←{redirect_pc[31:2],2'b00}.
  - `misalign` is tied to 0.

## Test plan
- Reset, then `start`, with READ_WAIT=1 and memory words 0..3 = A0,A1,A2,A3, `instr_ready`=1 → `instr`=A0,A1,A2,A3 at `instr_pc` 0,4,8,C. First `instr_valid` 3 cycles after `start`, then one every 3 cycles. WE stays 1.
- `instr_ready`=0 after start → exactly 2 reads complete, then STALL with CS=1. Raising `instr_ready` for one cycle → one new read begins the following cycle.
- `redirect`=1 with `redirect_pc`=0x40 on the capture edge of address 8 → the word from 8 never appears. Next output is `instr_pc`=0x40.
- PC=0xFFFF_FFFC fetched → next `Address`=0x0000_0000.
- Reset asserted mid-READ → CS/OE=1 and `instr_valid`=0 after that edge. No fetch until `start`.
- `redirect_pc`=0x42:
  - with `ALIGN_CHECK_EN` → `misalign`=1, CS stays 1 indefinitely;
  - without it → next `Address`=0x40, `misalign`=0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_if
// Description : Memory read bus (active-low CS/WE/OE word interface) and the
//               Control Unit instruction handshake used by instruction_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
    // memory side
    logic [31:0] Address;
    logic [31:0] Data;
    logic        CS;
    logic        WE;
    logic        OE;
    // Control Unit side
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign;

    modport master (
        output Address, CS, WE, OE,
        output instr, instr_pc, instr_valid, misalign,
        input  Data, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  Address, CS, WE, OE,
        input  instr, instr_pc, instr_valid, misalign,
        output Data, instr_ready, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Reads program words from memory over the active-low CS/OE
//               bus and feeds them to the Control Unit through a 2-entry
//               prefetch buffer. Supports PC redirect with buffer flush.
//               Optional macro ALIGN_CHECK_EN: misaligned redirect sets the
//               sticky misalign flag and halts fetching until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          READ_WAIT = 1
) (
    input  wire logic            clock,
    input  wire logic            reset,
    input  wire logic            start,
    instruction_fetch_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        GAP   = 3'd2,
        STALL = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT);

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [3:0]  cnt, cnt_n;
    logic        push, flush, misalign_set, pop;

    // second buffer slot; the head slot lives directly in instr/instr_pc
    logic [31:0] slot1_data, slot1_pc;
    logic        slot1_valid;

    assign pop    = bus.instr_valid && bus.instr_ready;
    assign bus.WE = 1'b1;

`ifndef ALIGN_CHECK_EN
    // the low PC bits are deliberately dropped when alignment checking is off
    logic unused_lsbs;
    assign unused_lsbs = ^bus.redirect_pc[1:0];
`endif

    // next-state, next-PC and buffer control decisions
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        cnt_n        = cnt;
        push         = 1'b0;
        flush        = 1'b0;
        misalign_set = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = READ;
                    pc_n    = RESET_PC;
                    cnt_n   = 4'd0;
                end
            end
            READ: begin
                if (cnt == WAIT_LAST) begin
                    push    = 1'b1;
                    pc_n    = pc + 32'd4;
                    cnt_n   = 4'd0;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            GAP: begin
                // a pop this edge always frees a slot; otherwise need slot1 empty
                state_n = (!slot1_valid || pop) ? READ : STALL;
                cnt_n   = 4'd0;
            end
            STALL: begin
                if (!slot1_valid) begin
                    state_n = READ;
                end
                cnt_n = 4'd0;
            end
            HALT: begin
                state_n = HALT;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // redirect overrides everything, including a coincident capture
        if (bus.redirect && (state != HALT)) begin
            push  = 1'b0;
            flush = 1'b1;
            cnt_n = 4'd0;
`ifdef ALIGN_CHECK_EN
            if (bus.redirect_pc[1:0] != 2'b00) begin
                misalign_set = 1'b1;
                state_n      = HALT;
            end else begin
                pc_n    = bus.redirect_pc;
                state_n = GAP;
            end
`else
            pc_n    = {bus.redirect_pc[31:2], 2'b00};
            state_n = GAP;
`endif
        end
    end

    // state, PC, counter and registered bus outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            cnt          <= 4'd0;
            bus.Address  <= 32'd0;
            bus.CS       <= 1'b1;
            bus.OE       <= 1'b1;
            bus.misalign <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            cnt   <= cnt_n;
            // address is loaded only when a read begins, so it is stable under CS=0
            if ((state_n == READ) && (state != READ)) begin
                bus.Address <= pc_n;
            end
            bus.CS       <= (state_n != READ);
            bus.OE       <= (state_n != READ);
            bus.misalign <= bus.misalign | misalign_set;
        end
    end

    // 2-entry shift FIFO: head in instr/instr_pc, overflow in slot1
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.instr       <= 32'd0;
            bus.instr_pc    <= 32'd0;
            bus.instr_valid <= 1'b0;
            slot1_data      <= 32'd0;
            slot1_pc        <= 32'd0;
            slot1_valid     <= 1'b0;
        end else if (flush) begin
            bus.instr_valid <= 1'b0;
            slot1_valid     <= 1'b0;
        end else if (push && pop) begin
            if (slot1_valid) begin
                bus.instr    <= slot1_data;
                bus.instr_pc <= slot1_pc;
                slot1_data   <= bus.Data;
                slot1_pc     <= pc;
            end else begin
                bus.instr    <= bus.Data;
                bus.instr_pc <= pc;
            end
        end else if (pop) begin
            bus.instr       <= slot1_data;
            bus.instr_pc    <= slot1_pc;
            bus.instr_valid <= slot1_valid;
            slot1_valid     <= 1'b0;
        end else if (push) begin
            if (!bus.instr_valid) begin
                bus.instr       <= bus.Data;
                bus.instr_pc    <= pc;
                bus.instr_valid <= 1'b1;
            end else begin
                slot1_data  <= bus.Data;
                slot1_pc    <= pc;
                slot1_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch with
//               READ_WAIT=1, RESET_PC=0. Memory returns addr ^ 32'hA5A5_0000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    int   tests = 0;
    int   fails = 0;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .READ_WAIT (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // memory model: drives a known pattern only while the read is enabled
    assign bus.Data = (!bus.CS && !bus.OE) ? (bus.Address ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;

        // reset state
        tick();
        tick();
        check("rst_cs", 32'(bus.CS), 32'd1);
        check("rst_oe", 32'(bus.OE), 32'd1);
        check("rst_we", 32'(bus.WE), 32'd1);
        check("rst_addr", bus.Address, 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_pc", bus.instr_pc, 32'd0);
        check("rst_mis", 32'(bus.misalign), 32'd0);

        reset = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        check("idle_cs", 32'(bus.CS), 32'd1);

        // streaming fetch of words 0..3
        start = 1'b1;
        tick();                                     // E0
        start = 1'b0;
        check("e0_cs", 32'(bus.CS), 32'd0);
        check("e0_oe", 32'(bus.OE), 32'd0);
        check("e0_addr", bus.Address, 32'd0);
        check("e0_valid", 32'(bus.instr_valid), 32'd0);
        tick();                                     // E1
        check("e1_valid", 32'(bus.instr_valid), 32'd0);
        tick();                                     // E2 capture word 0
        check("w0_valid", 32'(bus.instr_valid), 32'd1);
        check("w0_instr", bus.instr, 32'hA5A5_0000);
        check("w0_pc", bus.instr_pc, 32'h0);
        check("w0_cs", 32'(bus.CS), 32'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("wk_addr", bus.Address, 32'(4 * k));
            check("wk_cs", 32'(bus.CS), 32'd0);
            check("wk_valid0", 32'(bus.instr_valid), 32'd0);
            tick();
            check("wk_valid1", 32'(bus.instr_valid), 32'd0);
            tick();
            check("wk_valid", 32'(bus.instr_valid), 32'd1);
            check("wk_instr", bus.instr, 32'hA5A5_0000 | 32'(4 * k));
            check("wk_pc", bus.instr_pc, 32'(4 * k));
            check("wk_we", 32'(bus.WE), 32'd1);
        end
        tick();                                     // next read at 0x10
        check("r10_addr", bus.Address, 32'h10);
        check("r10_cs", 32'(bus.CS), 32'd0);

        // reset in the middle of a read
        reset = 1'b0;
        tick();
        check("mid_cs", 32'(bus.CS), 32'd1);
        check("mid_oe", 32'(bus.OE), 32'd1);
        check("mid_valid", 32'(bus.instr_valid), 32'd0);
        check("mid_addr", bus.Address, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        check("nostart_cs", 32'(bus.CS), 32'd1);

        // back-pressure: two reads fill the buffer, then stall
        bus.instr_ready = 1'b0;
        start = 1'b1;
        tick();                                     // E0
        start = 1'b0;
        tick();
        tick();                                     // capture 0
        tick();                                     // GAP -> READ 4
        check("bp_addr4", bus.Address, 32'h4);
        check("bp_cs4", 32'(bus.CS), 32'd0);
        tick();
        tick();                                     // capture 4, buffer full
        tick();                                     // STALL
        check("stall_cs", 32'(bus.CS), 32'd1);
        tick();
        tick();
        check("stall_cs2", 32'(bus.CS), 32'd1);
        check("stall_head", bus.instr_pc, 32'h0);
        check("stall_instr", bus.instr, 32'hA5A5_0000);
        bus.instr_ready = 1'b1;
        tick();                                     // one pop
        bus.instr_ready = 1'b0;
        check("pop_head", bus.instr_pc, 32'h4);
        check("pop_cs", 32'(bus.CS), 32'd1);
        tick();
        check("resume_cs", 32'(bus.CS), 32'd0);
        check("resume_addr", bus.Address, 32'h8);
        tick();
        tick();                                     // capture 8
        tick();
        check("restall_cs", 32'(bus.CS), 32'd1);
        check("restall_head", bus.instr_pc, 32'h4);

        // redirect on the capture edge of address 8
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.instr_ready = 1'b1;
        start = 1'b1;
        tick();                                     // E0
        start = 1'b0;
        tick();
        tick();                                     // word 0
        tick();
        tick();
        tick();                                     // word 4
        check("rd_pc4", bus.instr_pc, 32'h4);
        tick();
        check("rd_addr8", bus.Address, 32'h8);
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();                                     // capture edge of 8
        bus.redirect = 1'b0;
        check("rd_flush", 32'(bus.instr_valid), 32'd0);
        check("rd_cs", 32'(bus.CS), 32'd1);
        tick();
        check("rd_addr40", bus.Address, 32'h40);
        tick();
        tick();
        check("rd_valid", 32'(bus.instr_valid), 32'd1);
        check("rd_pc40", bus.instr_pc, 32'h40);
        check("rd_instr40", bus.instr, 32'hA5A5_0040);

        // address wrap at the top of memory
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0;
        check("wr_flush", 32'(bus.instr_valid), 32'd0);
        tick();
        check("wr_addr", bus.Address, 32'hFFFF_FFFC);
        tick();
        tick();
        check("wr_pc", bus.instr_pc, 32'hFFFF_FFFC);
        check("wr_instr", bus.instr, 32'h5A5A_FFFC);
        tick();
        check("wr_next", bus.Address, 32'h0);
        check("wr_cs", 32'(bus.CS), 32'd0);

        // misaligned redirect
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h42;
        tick();
        bus.redirect = 1'b0;
        check("mis_cs0", 32'(bus.CS), 32'd1);
`ifdef ALIGN_CHECK_EN
        check("mis_flag", 32'(bus.misalign), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("halt_cs", 32'(bus.CS), 32'd1);
            tick();
        end
        check("halt_valid", 32'(bus.instr_valid), 32'd0);
        check("halt_flag", 32'(bus.misalign), 32'd1);
`else
        check("mis_flag", 32'(bus.misalign), 32'd0);
        tick();
        check("mis_addr", bus.Address, 32'h40);
        check("mis_cs1", 32'(bus.CS), 32'd0);
        check("mis_flag2", 32'(bus.misalign), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
